fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the fetch stage: owns the PC register and drives the instruction memory
//  through a req/done handshake that tolerates variable latency.
//  Holds the fetched word for decode and honours decode stall, branch redirect and halt.
//  Sits between the instruction memory and the decode stage; produces PC+2 for the
//  branch/JAL datapath.
// PARAMETERS
//  RESET_PC  16'h0000  PC loaded on reset
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   asynchronous, active-low reset
//  stall        in   1   decode cannot accept; hold the current instruction
//  redirect     in   1   taken branch/jump; load redirect_pc
//  redirect_pc  in   16  redirect target
//  halt         in   1   current instr (instr_valid) is HALT; valid only with instr_valid
//  imem_req     out  1   memory request; held with stable imem_addr until imem_done
//  imem_addr    out  16  fetch address (= pc)
//  imem_done    in   1   memory response valid this cycle
//  imem_rdata   in   16  instruction word, sampled when imem_done=1
//  instr        out  16  instruction to decode
//  instr_pc     out  16  address of instr
//  instr_valid  out  1   instr/instr_pc valid
//  pc_plus2     out  16  instr_pc + 2 (mod 2^16)
//  halted       out  1   sequencer in HALT
//  err          out  1   sticky: PC wrap or misaligned redirect
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0,
//   imem_req=0, halted=0, err=0, redir_pend=0. All outputs registered except pc_plus2.
//  States: IDLE, FETCH, VALID, HALT.
//  IDLE: one cycle after reset release, then FETCH. No request.
//  FETCH: imem_req=1, imem_addr=pc; pc/addr stay stable until imem_done.
//   redirect while in FETCH, done=0: pc_next=redirect_pc stored, redir_pend=1; request kept.
//   imem_done with redirect or redir_pend: response discarded, pc<=target, redir_pend<=0,
//    stay FETCH (new request issued the next cycle).
//   imem_done, no redirect: instr<=imem_rdata, instr_pc<=pc, pc<=pc+2,
//    instr_valid<=1, -> VALID.
//   Minimum latency: memory with done in the request cycle -> instr_valid 1 cycle later.
//  VALID: instr_valid=1, imem_req=0. Priority redirect > halt > stall:
//   redirect: instr_valid<=0, pc<=redirect_pc, -> FETCH.
//   halt: instr_valid<=0, -> HALT.
//   stall: hold instr/instr_pc/instr_valid unchanged.
//   else: word consumed, instr_valid<=0, -> FETCH.
//  HALT: halted=1, imem_req=0, instr_valid=0; redirect/stall ignored; exit only by reset.
//  Arithmetic: pc+2 is 16-bit unsigned. If pc==16'hFFFE when incremented, err<=1, -> HALT
//   after delivering that instruction (VALID still presented once).
//  redirect_pc[0]=1 accepted -> err<=1, -> HALT, no fetch from the odd address.
//  err never clears except by reset.
//  Reset mid-transaction: imem_req drops immediately (async); in-flight response ignored.
//  redirect/halt/stall in IDLE or HALT have no effect.
// TESTING
//  1. Reset, RESET_PC=0, done same cycle -> instr_pc 0,2,4 valid every 2nd cycle; pc_plus2 2,4,6.
//  2. done delayed 3 cycles -> imem_req high 4 cycles, imem_addr stable, instr_valid 1 cycle after done.
//  3. stall=1 for 5 cycles in VALID -> instr/instr_pc unchanged, no imem_req; fetch resumes at pc+2.
//  4. redirect to 16'h0040 mid-wait, then done with 16'hDEAD -> DEAD never valid; next req addr 0x0040.
//  5. halt with instr_valid -> halted=1 next cycle, imem_req stays 0 for 20 cycles despite redirect.
//  6. redirect_pc=16'hFFFE then fetch -> instr_pc FFFE valid, err=1, halted=1; redirect 16'h0011 from reset -> err=1, no req.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : Fetch-stage sequencer. Owns the PC, drives the instruction
//             memory through a req/done handshake with variable latency,
//             holds the fetched word for decode and honours stall, branch
//             redirect and halt. Produces PC+2 for the branch/JAL datapath.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_done_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] instr_o,
    output logic [15:0] instr_pc_o,
    output logic        instr_valid_o,
    output logic [15:0] pc_plus2_o,
    output logic        halted_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [15:0] C_PC_LAST = 16'hFFFE;
    localparam logic [15:0] C_PC_STEP = 16'd2;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] redir_pc_q;
    logic        redir_pend_q;
    logic [15:0] instr_q;
    logic [15:0] instr_pc_q;
    logic        instr_valid_q;
    logic        imem_req_q;
    logic        halted_q;
    logic        err_q;

    // Sequential PC successor and the conditions derived from it
    logic [15:0] pc_seq_d;
    logic        pc_wrap_d;
    logic        redir_odd_d;
    logic        consume_d;

    // Next sequential PC (16-bit wrap) and the qualifying conditions
    always_comb begin
        pc_seq_d    = pc_q + C_PC_STEP;
        pc_wrap_d   = (pc_q == C_PC_LAST);
        redir_odd_d = redirect_i && redirect_pc_i[0];
        // Decode lets go of the held word unless it is stalling; redirect
        // and halt take precedence over stall.
        consume_d   = redirect_i || halt_i || !stall_i;
    end

    // Fetch sequencing FSM; all outputs except pc_plus2 are registered here
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            redir_pc_q    <= 16'h0000;
            redir_pend_q  <= 1'b0;
            instr_q       <= 16'h0000;
            instr_pc_q    <= 16'h0000;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            halted_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // One quiet cycle after reset release, then start fetching
                    state_q    <= ST_FETCH;
                    imem_req_q <= 1'b1;
                end

                ST_FETCH: begin
                    if (redir_odd_d) begin
                        // Misaligned target: never fetch from it, stop for good
                        err_q        <= 1'b1;
                        halted_q     <= 1'b1;
                        imem_req_q   <= 1'b0;
                        redir_pend_q <= 1'b0;
                        state_q      <= ST_HALT;
                    end else if (imem_done_i) begin
                        if (redirect_i) begin
                            // Response belongs to the wrong path; refetch at target
                            pc_q         <= redirect_pc_i;
                            redir_pend_q <= 1'b0;
                        end else if (redir_pend_q) begin
                            // Redirect arrived while waiting; drop this response
                            pc_q         <= redir_pc_q;
                            redir_pend_q <= 1'b0;
                        end else begin
                            instr_q       <= imem_rdata_i;
                            instr_pc_q    <= pc_q;
                            pc_q          <= pc_seq_d;
                            instr_valid_q <= 1'b1;
                            imem_req_q    <= 1'b0;
                            state_q       <= ST_VALID;
                            // Last even address: deliver it, then stop on exit
                            if (pc_wrap_d) begin
                                err_q <= 1'b1;
                            end
                        end
                    end else if (redirect_i) begin
                        // Address must stay stable until done; remember target
                        redir_pc_q   <= redirect_pc_i;
                        redir_pend_q <= 1'b1;
                    end
                end

                ST_VALID: begin
                    if (consume_d) begin
                        instr_valid_q <= 1'b0;
                        if (redir_odd_d || err_q) begin
                            // err_q here means the PC wrapped on this word
                            err_q    <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else if (redirect_i) begin
                            pc_q       <= redirect_pc_i;
                            imem_req_q <= 1'b1;
                            state_q    <= ST_FETCH;
                        end else if (halt_i) begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else begin
                            imem_req_q <= 1'b1;
                            state_q    <= ST_FETCH;
                        end
                    end
                end

                ST_HALT: begin
                    // Terminal until reset; inputs are ignored
                    halted_q      <= 1'b1;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end

                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_req_o    = imem_req_q;
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = instr_valid_q;
    assign halted_o      = halted_q;
    assign err_o         = err_q;
    assign pc_plus2_o    = instr_pc_q + C_PC_STEP;

endmodule

`default_nettype wire
